// File: rtl/vertex_load_buffer_if.sv
// vertex_load_buffer_if: word stream in, parallel V0-V7 register file write out
interface vertex_load_buffer_if;
    logic        in_valid;
    logic [15:0] in_data;
    logic        in_ready;
    logic        wr_hold;
    logic        flush;
    logic        we_VPU;
    logic [15:0] wrt_V0, wrt_V1, wrt_V2, wrt_V3, wrt_V4, wrt_V5, wrt_V6, wrt_V7;
    logic        busy;
    logic [2:0]  fill_cnt;
    modport slave (
        input  in_valid, in_data, wr_hold, flush,
        output in_ready, we_VPU, busy, fill_cnt,
        output wrt_V0, wrt_V1, wrt_V2, wrt_V3, wrt_V4, wrt_V5, wrt_V6, wrt_V7
    );
    modport master (
        output in_valid, in_data, wr_hold, flush,
        input  in_ready, we_VPU, busy, fill_cnt,
        input  wrt_V0, wrt_V1, wrt_V2, wrt_V3, wrt_V4, wrt_V5, wrt_V6, wrt_V7
    );
endinterface

// File: rtl/vertex_load_buffer.sv
// vertex_load_buffer: ping-pong gather of 8 vertex words into one parallel V0-V7 write
module vertex_load_buffer (
    input  logic                       clk,
    input  logic                       rst,
    vertex_load_buffer_if.slave        bus
);
    typedef enum logic [1:0] {EMPTY, FILLING, FULL} bank_st_t;
    bank_st_t    r_st [2];
    bank_st_t    w_st [2];
    logic [15:0] r_bank [2][8];
    logic [15:0] r_wrt [8];
    logic        r_fill_sel;
    logic        r_cmt_sel;
    logic        r_we;
    logic [2:0]  r_fill_cnt;
    logic        w_clr;
    logic        w_commit;
    logic        w_fill_blocked;
    logic        w_accept;
    assign w_clr    = rst | bus.flush;
    assign w_commit = (r_st[r_cmt_sel] == FULL) & !bus.wr_hold & !bus.flush;
    // a bank committing at this edge may take a new word at the same edge
    assign w_fill_blocked = (r_st[r_fill_sel] == FULL) & !(w_commit & (r_cmt_sel == r_fill_sel));
    assign bus.in_ready   = !w_clr & !w_fill_blocked;
    assign w_accept       = bus.in_valid & bus.in_ready;
    always_comb begin
        w_st = r_st;
        if (w_commit) w_st[r_cmt_sel] = EMPTY;
        if (w_accept) w_st[r_fill_sel] = (r_fill_cnt == 3'd7) ? FULL : FILLING;
        if (w_clr) begin
            w_st[0] = EMPTY;
            w_st[1] = EMPTY;
        end
    end
    always_ff @(posedge clk) begin
        r_st <= w_st;
        if (w_clr) begin
            r_fill_cnt <= 3'd0;
            r_fill_sel <= 1'b0;
            r_cmt_sel  <= 1'b0;
            r_we       <= 1'b0;
        end else begin
            r_we <= w_commit;
            if (w_accept) begin
                r_fill_cnt <= r_fill_cnt + 3'd1;
                if (r_fill_cnt == 3'd7) r_fill_sel <= !r_fill_sel;
            end
            if (w_commit) r_cmt_sel <= !r_cmt_sel;
        end
    end
    always_ff @(posedge clk) begin
        if (rst) r_wrt <= '{default: 16'h0000};
        else if (w_commit) r_wrt <= r_bank[r_cmt_sel];
    end
    always_ff @(posedge clk) begin
        if (w_accept) r_bank[r_fill_sel][r_fill_cnt] <= bus.in_data;
    end
    assign bus.we_VPU   = r_we;
    assign bus.busy     = (r_st[0] != EMPTY) | (r_st[1] != EMPTY);
    assign bus.fill_cnt = r_fill_cnt;
    assign bus.wrt_V0   = r_wrt[0];
    assign bus.wrt_V1   = r_wrt[1];
    assign bus.wrt_V2   = r_wrt[2];
    assign bus.wrt_V3   = r_wrt[3];
    assign bus.wrt_V4   = r_wrt[4];
    assign bus.wrt_V5   = r_wrt[5];
    assign bus.wrt_V6   = r_wrt[6];
    assign bus.wrt_V7   = r_wrt[7];
endmodule
